// File: rtl/poz_pkg.sv
// Shared definitions for the POZ comparator datapath: sample width, comparator flag
// encoding and the min/max tracker FSM state constants.
package poz_pkg;

    localparam int unsigned POZ_W = 4;

    // Comparator flags packed as {x, y, z}: x = a>b, y = a<b, z = a==b (one-hot).
    localparam logic [2:0] POZ_GT = 3'b100;
    localparam logic [2:0] POZ_LT = 3'b010;
    localparam logic [2:0] POZ_EQ = 3'b001;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

endpackage

// File: rtl/POZ_COMPARE.sv
// Combinational 4-bit unsigned comparator cell with bit-split operand ports and
// one-hot greater/less/equal flags.
module POZ_COMPARE
    import poz_pkg::*;
(
    input  logic a_0,
    input  logic a_1,
    input  logic a_2,
    input  logic a_3,
    input  logic b_0,
    input  logic b_1,
    input  logic b_2,
    input  logic b_3,
    output logic x,
    output logic y,
    output logic z
);

    logic [POZ_W-1:0] a;
    logic [POZ_W-1:0] b;
    logic [2:0]       flags;

    assign a = {a_3, a_2, a_1, a_0};
    assign b = {b_3, b_2, b_1, b_0};

    always_comb begin
        flags = POZ_EQ;
        if (a > b) begin
            flags = POZ_GT;
        end else if (a < b) begin
            flags = POZ_LT;
        end
    end

    assign {x, y, z} = flags;

endmodule

// File: rtl/poz_minmax_tracker.sv
// Frame-level running max/min/count tracker built on two POZ_COMPARE cells.
// Define POZ_MINMAX_INDEX_EN to add the first-occurrence max/min index outputs.
module poz_minmax_tracker
    import poz_pkg::*;
#(
    parameter int unsigned W     = POZ_W,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_max,
    output logic [W-1:0]     m_min,
    output logic [CNT_W-1:0] m_count
`ifdef POZ_MINMAX_INDEX_EN
    ,
    output logic [CNT_W-1:0] m_max_idx,
    output logic [CNT_W-1:0] m_min_idx
`endif
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     max_q, max_d;
    logic [W-1:0]     min_q, min_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       flags_max;
    logic [2:0]       flags_min;
    logic             accept;

`ifdef POZ_MINMAX_INDEX_EN
    logic [CNT_W-1:0] max_idx_q, max_idx_d;
    logic [CNT_W-1:0] min_idx_q, min_idx_d;
    logic [CNT_W-1:0] idx_pos;

    // Once the counter has saturated the true position is unknown; pin it below the cap.
    assign idx_pos = (count_q == CntMax) ? CntMax - CNT_W'(1) : count_q;
`endif

    POZ_COMPARE u_cmp_max (
        .a_0 (s_data[0]),
        .a_1 (s_data[1]),
        .a_2 (s_data[2]),
        .a_3 (s_data[3]),
        .b_0 (max_q[0]),
        .b_1 (max_q[1]),
        .b_2 (max_q[2]),
        .b_3 (max_q[3]),
        .x   (flags_max[2]),
        .y   (flags_max[1]),
        .z   (flags_max[0])
    );

    POZ_COMPARE u_cmp_min (
        .a_0 (s_data[0]),
        .a_1 (s_data[1]),
        .a_2 (s_data[2]),
        .a_3 (s_data[3]),
        .b_0 (min_q[0]),
        .b_1 (min_q[1]),
        .b_2 (min_q[2]),
        .b_3 (min_q[3]),
        .x   (flags_min[2]),
        .y   (flags_min[1]),
        .z   (flags_min[0])
    );

    assign s_ready = (state_q == StIdle) || (state_q == StAccum);
    assign m_valid = (state_q == StDone);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        count_d = count_q;
`ifdef POZ_MINMAX_INDEX_EN
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    max_d   = s_data;
                    min_d   = s_data;
                    count_d = CNT_W'(1);
`ifdef POZ_MINMAX_INDEX_EN
                    max_idx_d = '0;
                    min_idx_d = '0;
`endif
                    state_d = s_last ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    // Ties keep the stored value so the first occurrence wins.
                    if (flags_max == POZ_GT) begin
                        max_d = s_data;
`ifdef POZ_MINMAX_INDEX_EN
                        max_idx_d = idx_pos;
`endif
                    end
                    if (flags_min == POZ_LT) begin
                        min_d = s_data;
`ifdef POZ_MINMAX_INDEX_EN
                        min_idx_d = idx_pos;
`endif
                    end
                    if (count_q != CntMax) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (s_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            max_q   <= '0;
            min_q   <= '0;
            count_q <= '0;
`ifdef POZ_MINMAX_INDEX_EN
            max_idx_q <= '0;
            min_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            count_q <= count_d;
`ifdef POZ_MINMAX_INDEX_EN
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
`endif
        end
    end

    assign m_max   = max_q;
    assign m_min   = min_q;
    assign m_count = count_q;
`ifdef POZ_MINMAX_INDEX_EN
    assign m_max_idx = max_idx_q;
    assign m_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_poz_minmax_tracker.sv
// Self-checking bench for poz_minmax_tracker: scoreboarded frames, backpressure,
// mid-frame reset and counter saturation (on a second instance with CNT_W = 2).
module tb_poz_minmax_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [3:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       m_ready = 1'b1;

    logic       s_ready, m_valid;
    logic [3:0] m_max, m_min;
    logic [7:0] m_count;
    logic       sat_s_ready, sat_m_valid;
    logic [3:0] sat_max, sat_min;
    logic [1:0] sat_count;
`ifdef POZ_MINMAX_INDEX_EN
    logic [7:0] m_max_idx, m_min_idx;
    logic [1:0] sat_max_idx, sat_min_idx;
`endif

    always #5 clk = ~clk;

    poz_minmax_tracker #(.W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_max     (m_max),
        .m_min     (m_min),
        .m_count   (m_count)
`ifdef POZ_MINMAX_INDEX_EN
        ,
        .m_max_idx (m_max_idx),
        .m_min_idx (m_min_idx)
`endif
    );

    poz_minmax_tracker #(.W(4), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (sat_s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (sat_m_valid),
        .m_ready   (m_ready),
        .m_max     (sat_max),
        .m_min     (sat_min),
        .m_count   (sat_count)
`ifdef POZ_MINMAX_INDEX_EN
        ,
        .m_max_idx (sat_max_idx),
        .m_min_idx (sat_min_idx)
`endif
    );

    typedef struct {
        logic [3:0] mx;
        logic [3:0] mn;
        int         cnt;
        int         mxi;
        int         mni;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] frame[$];
    int         n_cmp = 0;
    int         n_err = 0;

    // Reference: first occurrence wins, count saturates, post-saturation index is cap-1.
    function automatic exp_t model(input int cw);
        exp_t e;
        int   cap = (1 << cw) - 1;
        int   pos;
        e.mx = frame[0]; e.mn = frame[0]; e.cnt = 1; e.mxi = 0; e.mni = 0;
        for (int i = 1; i < frame.size(); i++) begin
            pos = (e.cnt == cap) ? cap - 1 : e.cnt;
            if (frame[i] > e.mx) begin e.mx = frame[i]; e.mxi = pos; end
            if (frame[i] < e.mn) begin e.mn = frame[i]; e.mni = pos; end
            if (e.cnt < cap) e.cnt = e.cnt + 1;
        end
        return e;
    endfunction

    task automatic send_frame(input bit with_last);
        for (int i = 0; i < frame.size(); i++) begin
            int guard = 0;
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = frame[i];
            s_last  = with_last && (i == frame.size() - 1);
            while (!s_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called at the negedge right after the last sample was accepted.
    task automatic collect(input string name, input int stall);
        exp_t e;
        int   guard = 0;
        n_cmp++;
        if (m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_latency: m_valid=%0b required 1", name, m_valid);
        end
        while (!m_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (m_max !== e.mx) begin
            n_err++; $display("FAIL %s_max: got %0d required %0d", name, m_max, e.mx);
        end
        n_cmp++;
        if (m_min !== e.mn) begin
            n_err++; $display("FAIL %s_min: got %0d required %0d", name, m_min, e.mn);
        end
        n_cmp++;
        if (m_count !== 8'(e.cnt)) begin
            n_err++; $display("FAIL %s_count: got %0d required %0d", name, m_count, e.cnt);
        end
`ifdef POZ_MINMAX_INDEX_EN
        n_cmp++;
        if (m_max_idx !== 8'(e.mxi)) begin
            n_err++; $display("FAIL %s_max_idx: got %0d required %0d", name, m_max_idx, e.mxi);
        end
        n_cmp++;
        if (m_min_idx !== 8'(e.mni)) begin
            n_err++; $display("FAIL %s_min_idx: got %0d required %0d", name, m_min_idx, e.mni);
        end
`endif
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            n_cmp++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_max !== e.mx || m_min !== e.mn) begin
                n_err++;
                $display("FAIL %s_hold%0d: valid=%0b ready=%0b max=%0d min=%0d required 1 0 %0d %0d",
                         name, k, m_valid, s_ready, m_max, m_min, e.mx, e.mn);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_post: m_valid=%0b s_ready=%0b required 0 1", name, m_valid, s_ready);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_max !== 4'd0 || m_min !== 4'd0 ||
            m_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset: valid=%0b ready=%0b max=%0d min=%0d count=%0d required 0 1 0 0 0",
                     m_valid, s_ready, m_max, m_min, m_count);
        end
`ifdef POZ_MINMAX_INDEX_EN
        n_cmp++;
        if (m_max_idx !== 8'd0 || m_min_idx !== 8'd0) begin
            n_err++;
            $display("FAIL reset_idx: got %0d %0d required 0 0", m_max_idx, m_min_idx);
        end
`endif
    endtask

    task automatic test_basic();
        frame = '{4'd7, 4'd3, 4'd12, 4'd9};
        sb.push_back(model(8));
        send_frame(1'b1);
        collect("basic", 0);
    endtask

    task automatic test_single();
        frame = '{4'd11};
        sb.push_back(model(8));
        send_frame(1'b1);
        collect("single", 0);
    endtask

    task automatic test_ties();
        frame = '{4'd8, 4'd8, 4'd8};
        sb.push_back(model(8));
        send_frame(1'b1);
        collect("ties", 0);
    endtask

    task automatic test_back_to_back();
        frame = '{4'd0, 4'd15, 4'd4, 4'd15, 4'd0};
        sb.push_back(model(8));
        send_frame(1'b1);
        collect("b2b_a", 0);
        frame = '{4'd5, 4'd2, 4'd6};
        sb.push_back(model(8));
        send_frame(1'b1);
        collect("b2b_b", 0);
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        frame = '{4'd15, 4'd9};
        sb.push_back(model(8));
        send_frame(1'b1);
        collect("bp", 5);
    endtask

    task automatic test_reset_mid_frame();
        frame = '{4'd7, 4'd3};
        send_frame(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (m_valid !== 1'b0 || m_max !== 4'd0 || m_min !== 4'd0 || m_count !== 8'd0) begin
                n_err++;
                $display("FAIL midrst%0d: valid=%0b max=%0d min=%0d count=%0d required all 0",
                         k, m_valid, m_max, m_min, m_count);
            end
            @(negedge clk);
        end
        frame = '{4'd15, 4'd0};
        sb.push_back(model(8));
        send_frame(1'b1);
        collect("midrst_after", 0);
    endtask

    task automatic test_saturation();
        exp_t e;
        frame = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        e = model(2);
        sb.push_back(model(8));
        send_frame(1'b1);
        n_cmp++;
        if (sat_m_valid !== 1'b1 || sat_count !== 2'(e.cnt) || sat_max !== e.mx ||
            sat_min !== e.mn) begin
            n_err++;
            $display("FAIL sat: valid=%0b count=%0d max=%0d min=%0d required 1 %0d %0d %0d",
                     sat_m_valid, sat_count, sat_max, sat_min, e.cnt, e.mx, e.mn);
        end
`ifdef POZ_MINMAX_INDEX_EN
        n_cmp++;
        if (sat_max_idx !== 2'(e.mxi) || sat_min_idx !== 2'(e.mni)) begin
            n_err++;
            $display("FAIL sat_idx: got %0d %0d required %0d %0d",
                     sat_max_idx, sat_min_idx, e.mxi, e.mni);
        end
`endif
        collect("sat_wide", 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_ties();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
